// File: rtl/spi_regs_mc.sv
// Picoblaze port-bus register file for the SPI master: control, chip selects, burst counter, IRQ.
// Optional macro SPI_REGS_AUTO_CS_EN: auto-deselect all chip selects when the burst counter hits zero.
module spi_regs_mc #(
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter int         NUM_CS       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        port_id,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    input  logic              read_strobe,
    input  logic              write_strobe,
    input  logic [7:0]        rfdout,
    input  logic [7:0]        spsr,
    output logic              wfwe,
    output logic              rfre,
    output logic              wr_spsr,
    output logic              clear_spif,
    output logic              clear_wcol,
    output logic [7:0]        wfdin,
    output logic [NUM_CS-1:0] ncs_o,
    output logic [7:0]        spcr,
    output logic [7:0]        sper,
    output logic              irq
);
    localparam logic [2:0] OFF_SPCR = 3'd0;
    localparam logic [2:0] OFF_SPSR = 3'd1;
    localparam logic [2:0] OFF_SPDR = 3'd2;
    localparam logic [2:0] OFF_SPER = 3'd3;
    localparam logic [2:0] OFF_CSR  = 3'd4;
    localparam logic [2:0] OFF_IER  = 3'd5;
    localparam logic [2:0] OFF_ISR  = 3'd6;
    localparam logic [2:0] OFF_BCNT = 3'd7;

    logic [7:0]        offset;
    logic              hit;
    logic [2:0]        sel;
    logic              wr_en;
    logic              spif_prev;
    logic              spif_rise;
    logic              bcnt_wr;
    logic              burst_done;
    logic [1:0]        ier;
    logic [1:0]        isr;
    logic [1:0]        isr_next;
    logic [7:0]        bcnt;
    logic [7:0]        bcnt_next;
    logic [NUM_CS-1:0] ncs_next;
    logic [7:0]        csr_rd;
    logic [7:0]        rd_mux;

    // Subtraction keeps decode correct for any BASE_ADDRESS, aligned or not.
    assign offset = port_id - BASE_ADDRESS;
    assign hit    = (offset[7:3] == 5'd0);
    assign sel    = offset[2:0];
    assign wr_en  = write_strobe & hit;

    assign spif_rise = spsr[7] & ~spif_prev;
    assign bcnt_wr   = wr_en && (sel == OFF_BCNT);
    // A BCNT write overrides the decrement, so no 1->0 transition happens that cycle.
    assign burst_done = spif_rise && (bcnt == 8'd1) && !bcnt_wr;

    always_comb begin
        bcnt_next = bcnt;
        if (bcnt_wr)
            bcnt_next = data_in;
        else if (spif_rise && (bcnt != 8'd0))
            bcnt_next = bcnt - 8'd1;
    end

    always_comb begin
        isr_next = isr;
        if (wr_en && (sel == OFF_ISR))
            isr_next = isr & ~data_in[1:0];
        isr_next = isr_next | {burst_done, spif_rise};
    end

    always_comb begin
        ncs_next = ncs_o;
        if (wr_en && (sel == OFF_CSR))
            ncs_next = data_in[NUM_CS-1:0];
`ifdef SPI_REGS_AUTO_CS_EN
        if (burst_done)
            ncs_next = '1;
`endif
    end

    always_comb begin
        csr_rd = '0;
        csr_rd[NUM_CS-1:0] = ncs_o;
    end

    always_comb begin
        rd_mux = 8'h00;
        if (hit) begin
            case (sel)
                OFF_SPCR: rd_mux = spcr;
                OFF_SPSR: rd_mux = spsr;
                OFF_SPDR: rd_mux = rfdout;
                OFF_SPER: rd_mux = sper;
                OFF_CSR:  rd_mux = csr_rd;
                OFF_IER:  rd_mux = {6'b0, ier};
                OFF_ISR:  rd_mux = {6'b0, isr};
                default:  rd_mux = bcnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spcr       <= 8'h00;
            sper       <= 8'h00;
            wfdin      <= 8'h00;
            data_out   <= 8'h00;
            wfwe       <= 1'b0;
            rfre       <= 1'b0;
            wr_spsr    <= 1'b0;
            clear_spif <= 1'b0;
            clear_wcol <= 1'b0;
            ncs_o      <= '1;
            ier        <= 2'b00;
            isr        <= 2'b00;
            bcnt       <= 8'h00;
            irq        <= 1'b0;
            spif_prev  <= 1'b0;
        end else begin
            data_out   <= rd_mux;
            wfwe       <= wr_en && (sel == OFF_SPDR);
            rfre       <= read_strobe && hit && (sel == OFF_SPDR);
            wr_spsr    <= wr_en && (sel == OFF_SPSR);
            clear_spif <= wr_en && (sel == OFF_SPSR) && data_in[7];
            clear_wcol <= wr_en && (sel == OFF_SPSR) && data_in[6];
            if (wr_en && (sel == OFF_SPCR)) spcr  <= data_in;
            if (wr_en && (sel == OFF_SPER)) sper  <= data_in;
            if (wr_en && (sel == OFF_SPDR)) wfdin <= data_in;
            if (wr_en && (sel == OFF_IER))  ier   <= data_in[1:0];
            ncs_o     <= ncs_next;
            isr       <= isr_next;
            bcnt      <= bcnt_next;
            irq       <= |(isr & ier);
            spif_prev <= spsr[7];
        end
    end
endmodule

// File: tb/tb_spi_regs_mc.sv
// Directed self-checking bench for spi_regs_mc; expectations are hand-computed constants.
module tb_spi_regs_mc;
    localparam logic [7:0] BASE = 8'h00;
    localparam int NCS = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [7:0]     port_id = 8'h00;
    logic [7:0]     data_in = 8'h00;
    logic [7:0]     data_out;
    logic           read_strobe = 1'b0;
    logic           write_strobe = 1'b0;
    logic [7:0]     rfdout = 8'h00;
    logic [7:0]     spsr = 8'h00;
    logic           wfwe, rfre, wr_spsr, clear_spif, clear_wcol, irq;
    logic [7:0]     wfdin, spcr, sper;
    logic [NCS-1:0] ncs_o;

    int n_cmp = 0;
    int n_bad = 0;

    spi_regs_mc #(.BASE_ADDRESS(BASE), .NUM_CS(NCS)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
        .data_out(data_out), .read_strobe(read_strobe), .write_strobe(write_strobe),
        .rfdout(rfdout), .spsr(spsr), .wfwe(wfwe), .rfre(rfre), .wr_spsr(wr_spsr),
        .clear_spif(clear_spif), .clear_wcol(clear_wcol), .wfdin(wfdin),
        .ncs_o(ncs_o), .spcr(spcr), .sper(sper), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] o, input logic [7:0] d);
        port_id = BASE + {5'b0, o};
        data_in = d;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [2:0] o, input logic [7:0] e, input string tag);
        port_id = BASE + {5'b0, o};
        step();
        check(tag, data_out, e);
    endtask

    task automatic pulse();
        spsr = 8'h80;
        step();
        spsr = 8'h00;
        step();
    endtask

    int cnt;

    initial begin
        step(); step();
        reset = 1'b0;
        check("rst_ncs", ncs_o, 4'hF);
        check("rst_spcr", spcr, 0);
        check("rst_sper", sper, 0);
        check("rst_irq", irq, 0);
        check("rst_wfwe", wfwe, 0);
        rd(0, 8'h00, "rst_rd0");
        rd(3, 8'h00, "rst_rd3");
        rd(5, 8'h00, "rst_rd5");
        rd(6, 8'h00, "rst_rd6");
        rd(7, 8'h00, "rst_rd7");

        wr(4, 8'hFE);
        check("csr_ncs", ncs_o, 4'hE);
        wr(0, 8'h53);
        wr(3, 8'h02);
        check("spcr_out", spcr, 8'h53);
        check("sper_out", sper, 8'h02);
        rd(4, 8'h0E, "rd_csr");
        rd(0, 8'h53, "rd_spcr");
        rd(3, 8'h02, "rd_sper");
        rd(5, 8'h00, "rd_ier_ro");

        // SPDR write: one wfwe pulse
        wr(2, 8'hA5);
        check("wfdin", wfdin, 8'hA5);
        check("wfwe_hi", wfwe, 1);
        step();
        check("wfwe_lo", wfwe, 0);

        // SPDR decoded without strobe: no pop
        rfdout = 8'h3C;
        port_id = BASE + 8'd2;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rfre) cnt++;
        end
        check("no_pop", cnt, 0);
        check("rd_spdr", data_out, 8'h3C);
        read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        check("pop_hi", rfre, 1);
        step();
        check("pop_lo", rfre, 0);
        read_strobe = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rfre) cnt++;
        end
        read_strobe = 1'b0;
        step();
        check("held_pops", cnt, 3);
        check("held_end", rfre, 0);

        // SPSR write pulses
        wr(1, 8'hC0);
        check("wr_spsr_hi", wr_spsr, 1);
        check("clr_spif_hi", clear_spif, 1);
        check("clr_wcol_hi", clear_wcol, 1);
        step();
        check("wr_spsr_lo", {wr_spsr, clear_spif, clear_wcol}, 3'b000);
        wr(1, 8'h40);
        check("spsr40", {wr_spsr, clear_spif, clear_wcol}, 3'b101);
        step();

        // Burst of three SPIF rises
        wr(5, 8'h03);
        wr(7, 8'h03);
        spsr = 8'h80;
        step();
        check("irq_lat0", irq, 0);
        spsr = 8'h00;
        step();
        check("irq_lat1", irq, 1);
        rd(7, 8'h02, "bcnt2");
        pulse();
        rd(7, 8'h01, "bcnt1");
        pulse();
        rd(7, 8'h00, "bcnt0");
        rd(6, 8'h03, "isr_done");
        check("irq_done", irq, 1);
        wr(6, 8'h01);
        rd(6, 8'h02, "isr_w1c0");
        check("irq_keep", irq, 1);
        wr(6, 8'h02);
        step();
        check("irq_clr", irq, 0);
        rd(6, 8'h00, "isr_clr");

        // No wrap at zero
        pulse();
        rd(7, 8'h00, "bcnt_nowrap");
        rd(6, 8'h01, "isr_nowrap");
        wr(6, 8'h03);

        // Set beats W1C in the same cycle
        spsr = 8'h80;
        wr(6, 8'h01);
        spsr = 8'h00;
        rd(6, 8'h01, "isr_setwins");
        wr(6, 8'h03);

        // BCNT write beats decrement
        wr(7, 8'h02);
        spsr = 8'h80;
        wr(7, 8'h05);
        spsr = 8'h00;
        rd(7, 8'h05, "bcnt_wrwins");
        rd(6, 8'h01, "isr_wrwins");
        wr(6, 8'h03);

        // Final byte of a burst: optional auto-deselect
        wr(4, 8'hFD);
        wr(7, 8'h01);
        spsr = 8'h80;
        step();
        spsr = 8'h00;
`ifdef SPI_REGS_AUTO_CS_EN
        check("auto_cs", ncs_o, 4'hF);
`else
        check("auto_cs", ncs_o, 4'hD);
`endif
        rd(6, 8'h03, "isr_auto");

        // Reset mid-burst
        wr(4, 8'hFE);
        wr(7, 8'h03);
        reset = 1'b1;
        step();
        check("midrst_ncs", ncs_o, 4'hF);
        check("midrst_irq", irq, 0);
        reset = 1'b0;
        rd(7, 8'h00, "midrst_bcnt");
        rd(6, 8'h00, "midrst_isr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
